// File: rtl/anim_tick_gen.sv
// anim_tick_gen: multi-rate animation timebase.
// A prescaler divides clk down to a frame event every FRAME_TICKS clocks. N_CH channel
// dividers derive slower, frame-aligned ticks from that event, and a free-running counter
// counts frame events.
// Optional build macro ANIM_TICK_STEP_EN adds a 'step' input for single-frame stepping
// while the timebase is paused.
// FRAME_TICKS = CLK_HZ / FRAME_HZ must be at least 2.
module anim_tick_gen #(
   parameter int unsigned CLK_HZ   = 45_000_000,
   parameter int unsigned FRAME_HZ = 60,
   parameter int unsigned N_CH     = 4,
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned FCNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    resync,
`ifdef ANIM_TICK_STEP_EN
   input  logic                    step,
`endif
   input  logic [N_CH*DIV_W-1:0]   ch_div,
   input  logic [N_CH-1:0]         ch_en,
   output logic                    frame_tick,
   output logic [N_CH-1:0]         ch_tick,
   output logic [FCNT_W-1:0]       frame_cnt
);

   localparam int unsigned FRAME_TICKS = CLK_HZ / FRAME_HZ;
   localparam int unsigned PRE_W       = $clog2(FRAME_TICKS);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FRAME_TICKS - 1);

   logic [PRE_W-1:0]             presc_q, presc_d;
   logic                         frame_tick_q, frame_tick_d;
   logic [N_CH-1:0]              ch_tick_q, ch_tick_d;
   logic [N_CH-1:0][DIV_W-1:0]   ch_cnt_q, ch_cnt_d;
   logic [FCNT_W-1:0]            frame_cnt_q, frame_cnt_d;

   logic wrap;
   logic step_ev;
   logic frame_ev;

   // Terminal count of a channel; a programmed ratio of 0 behaves like 1.
   function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] div);
      return (div == '0) ? '0 : div - DIV_W'(1);
   endfunction

`ifdef ANIM_TICK_STEP_EN
   // A step only counts while paused; resync always wins.
   assign step_ev = step & ~en & ~resync;
`else
   assign step_ev = 1'b0;
`endif

   // Frame event: prescaler wrap while running, or a debug step while paused.
   always_comb begin
      wrap     = en & ~resync & (presc_q == PRE_LAST);
      frame_ev = wrap | step_ev;
   end

   // Prescaler next state: resync clears, en advances, otherwise hold.
   always_comb begin
      presc_d = presc_q;
      if (resync) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = wrap ? '0 : presc_q + PRE_W'(1);
      end
   end

   // Channel dividers are only evaluated on a frame event; '>=' lets a lowered ratio
   // fire on the next event instead of running on to wrap-around.
   always_comb begin
      ch_cnt_d  = ch_cnt_q;
      ch_tick_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (resync) begin
            ch_cnt_d[i] = '0;
         end else if (frame_ev) begin
            if (!ch_en[i]) begin
               ch_cnt_d[i] = '0;
            end else if (ch_cnt_q[i] >= last_cnt(ch_div[i*DIV_W +: DIV_W])) begin
               ch_cnt_d[i]  = '0;
               ch_tick_d[i] = 1'b1;
            end else begin
               ch_cnt_d[i] = ch_cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   // Frame pulse and frame counter next state.
   always_comb begin
      frame_tick_d = frame_ev;
      frame_cnt_d  = frame_ev ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         frame_tick_q <= 1'b0;
         ch_tick_q    <= '0;
         ch_cnt_q     <= '0;
         frame_cnt_q  <= '0;
      end else begin
         presc_q      <= presc_d;
         frame_tick_q <= frame_tick_d;
         ch_tick_q    <= ch_tick_d;
         ch_cnt_q     <= ch_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign frame_tick = frame_tick_q;
   assign ch_tick    = ch_tick_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_anim_tick_gen.sv
// Bench for anim_tick_gen with CLK_HZ=1000, FRAME_HZ=100 (10 clocks per frame), 4 channels,
// and a 4-bit frame counter so the counter wraps within a short run.
module tb_anim_tick_gen;

   localparam int unsigned NCH   = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned FW    = 4;
   localparam int          FLAST = 9;

   localparam logic [NCH*DW-1:0] D0 = {8'd4, 8'd3, 8'd1, 8'd0};
   localparam logic [NCH*DW-1:0] D1 = {8'd4, 8'd3, 8'd8, 8'd0};
   localparam logic [NCH*DW-1:0] D2 = {8'd4, 8'd3, 8'd2, 8'd0};

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                resync;
   logic [NCH*DW-1:0]   ch_div;
   logic [NCH-1:0]      ch_en;
   logic                frame_tick;
   logic [NCH-1:0]      ch_tick;
   logic [FW-1:0]       frame_cnt;
`ifdef ANIM_TICK_STEP_EN
   logic                step = 1'b0;
`endif

   always #5 clk = ~clk;

   anim_tick_gen #(
      .CLK_HZ   (1000),
      .FRAME_HZ (100),
      .N_CH     (NCH),
      .DIV_W    (DW),
      .FCNT_W   (FW)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .resync     (resync),
`ifdef ANIM_TICK_STEP_EN
      .step       (step),
`endif
      .ch_div     (ch_div),
      .ch_en      (ch_en),
      .frame_tick (frame_tick),
      .ch_tick    (ch_tick),
      .frame_cnt  (frame_cnt)
   );

   typedef struct packed {
      logic          ft;
      logic [NCH-1:0] ct;
      logic [FW-1:0]  fc;
   } exp_t;

   typedef struct {
      int              cycles;
      logic            en;
      logic            resync;
      logic [NCH-1:0]  ch_en;
      logic [NCH*DW-1:0] ch_div;
      int              n_frame;
      logic [NCH-1:0][7:0] n_ch;   // expected channel tick counts {ch3,ch2,ch1,ch0}
      int              fcnt_end;
      int              first_at;   // cycle of first frame_tick in phase, 0 = none expected
   } vec_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   int   m_presc;
   int   m_fcnt;
   int   m_cnt[NCH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_presc = 0;
      m_fcnt  = 0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      sb_q.delete();
   endtask

   // Predict the outputs registered at the coming edge from the inputs now applied.
   task automatic model_push();
      exp_t e;
      bit   ev;
      int   d;
      e  = '0;
      ev = 0;
      if (resync) begin
         m_presc = 0;
         for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      end else if (en) begin
         if (m_presc == FLAST) begin
            m_presc = 0;
            ev      = 1;
         end else begin
            m_presc++;
         end
      end
      if (ev) begin
         m_fcnt = (m_fcnt + 1) % (1 << FW);
         for (int c = 0; c < NCH; c++) begin
            d = int'(ch_div[c*DW +: DW]);
            if (d == 0) d = 1;
            if (!ch_en[c]) m_cnt[c] = 0;
            else if (m_cnt[c] >= d - 1) begin
               m_cnt[c] = 0;
               e.ct[c]  = 1'b1;
            end else m_cnt[c]++;
         end
      end
      e.ft = ev;
      e.fc = FW'(m_fcnt);
      sb_q.push_back(e);
   endtask

   // One clock: push expectation, take the edge, pop and compare.
   task automatic tick();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("cycle_outputs", {23'd0, frame_tick, ch_tick, frame_cnt}, {23'd0, e});
   endtask

   vec_t vecs[13];

   initial begin
      int   nf;
      int   first;
      int   nc[NCH];
      logic [FW-1:0] prev_fc;
      bit   wrap_seen;

      vecs[0]  = '{30, 1, 0, 4'hF, D0, 3, {8'd0, 8'd1, 8'd3, 8'd3}, 3, 10};
      vecs[1]  = '{90, 1, 0, 4'hF, D0, 9, {8'd3, 8'd3, 8'd9, 8'd9}, 12, 10};
      vecs[2]  = '{6, 1, 0, 4'hF, D0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 12, 0};
      vecs[3]  = '{25, 0, 0, 4'hF, D0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 12, 0};
      vecs[4]  = '{4, 1, 0, 4'hF, D0, 1, {8'd0, 8'd0, 8'd1, 8'd1}, 13, 4};
      vecs[5]  = '{9, 1, 0, 4'hF, D0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 13, 0};
      vecs[6]  = '{1, 1, 1, 4'hF, D0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 13, 0};
      vecs[7]  = '{10, 1, 0, 4'hF, D0, 1, {8'd0, 8'd0, 8'd1, 8'd1}, 14, 10};
      vecs[8]  = '{50, 1, 0, 4'hF, D1, 5, {8'd1, 8'd2, 8'd0, 8'd5}, 3, 10};
      vecs[9]  = '{40, 1, 0, 4'hF, D2, 4, {8'd1, 8'd1, 8'd2, 8'd4}, 7, 10};
      vecs[10] = '{20, 1, 0, 4'h5, D2, 2, {8'd0, 8'd1, 8'd0, 8'd2}, 9, 10};
      vecs[11] = '{30, 1, 0, 4'hF, D2, 3, {8'd0, 8'd1, 8'd1, 8'd3}, 12, 10};
      vecs[12] = '{40, 1, 0, 4'hF, D2, 4, {8'd1, 8'd1, 8'd2, 8'd4}, 0, 10};

      rst    = 1'b1;
      en     = 1'b0;
      resync = 1'b0;
      ch_div = D0;
      ch_en  = 4'hF;
      model_reset();
      #3;
      check("reset_async", {27'd0, frame_tick, ch_tick, frame_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", {27'd0, frame_tick, ch_tick, frame_cnt}, 32'd0);

      for (int v = 0; v < 13; v++) begin
         en     = vecs[v].en;
         resync = vecs[v].resync;
         ch_en  = vecs[v].ch_en;
         ch_div = vecs[v].ch_div;
         nf     = 0;
         first  = 0;
         for (int c = 0; c < NCH; c++) nc[c] = 0;
         for (int k = 1; k <= vecs[v].cycles; k++) begin
            tick();
            if (frame_tick === 1'b1) begin
               nf++;
               if (first == 0) first = k;
            end
            for (int c = 0; c < NCH; c++) if (ch_tick[c] === 1'b1) nc[c]++;
         end
         check($sformatf("vec%0d_frames", v), nf, vecs[v].n_frame);
         for (int c = 0; c < NCH; c++)
            check($sformatf("vec%0d_ch%0d_ticks", v, c), nc[c], int'(vecs[v].n_ch[c]));
         check($sformatf("vec%0d_frame_cnt", v), frame_cnt, vecs[v].fcnt_end);
         check($sformatf("vec%0d_first_tick", v), first, vecs[v].first_at);
      end
      resync = 1'b0;

      // Counter wrap over 17 frames from a fresh reset.
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      en        = 1'b1;
      ch_en     = 4'hF;
      ch_div    = D2;
      wrap_seen = 0;
      prev_fc   = frame_cnt;
      for (int k = 0; k < 170; k++) begin
         tick();
         if (frame_tick === 1'b1 && prev_fc == 4'd15 && frame_cnt == 4'd0) wrap_seen = 1;
         prev_fc = frame_cnt;
      end
      check("fcnt_wrap_seen", wrap_seen, 1);
      check("fcnt_after_17", frame_cnt, 1);
      check("tick_before_rst", {30'd0, frame_tick, ch_tick[0]}, 32'd3);

      // Asynchronous reset between edges must clear outputs immediately.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_mid", {27'd0, frame_tick, ch_tick, frame_cnt}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_state", {27'd0, frame_tick, ch_tick, frame_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
